// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C write master among NUM_REQ requesters.
// Optional macro I2C_TIMEOUT_EN adds a WAIT_DONE timeout that raises err and moves on.
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 300000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   overrun,
    input  logic                 clr_overrun,
    output logic                 i2c_start,
    output logic [7:0]           i2c_addr,
    output logic [7:0]           i2c_data,
    input  logic                 i2c_done,
    input  logic                 i2c_nack,
    output logic                 err,
    output logic [2:0]           grant_id,
    output logic                 busy
);

    // state     | meaning
    // IDLE      | waiting for a pending request, picks the next one round-robin
    // ISSUE     | one-cycle start strobe to the I2C master
    // WAIT_DONE | transaction in flight, waiting for i2c_done (or timeout)
    // GAP       | guard interval before the next transaction may start
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    localparam int IW      = $clog2(NUM_REQ);
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYC) ? GAP_CYCLES : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    state_t               state;
    logic [NUM_REQ-1:0]   pending;
    logic [NUM_REQ-1:0]   pending_nxt;
    logic [NUM_REQ-1:0]   overrun_nxt;
    logic [7:0]           slot_addr [NUM_REQ];
    logic [7:0]           slot_data [NUM_REQ];
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        rr_next;
    logic [IW-1:0]        sel_idx;
    logic                 sel_found;
    logic                 take;
    logic [CW-1:0]        cnt;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && pending[(int'(rr_ptr) + k) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign take    = (state == IDLE) && sel_found;
    assign rr_next = IW'((int'(grant_idx) + 1) % NUM_REQ);

    // A request on the same edge its slot is granted re-pends without counting as an overrun.
    always_comb begin
        pending_nxt = pending;
        overrun_nxt = clr_overrun ? '0 : overrun;
        if (take)
            pending_nxt[sel_idx] = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                if (pending[i] && !(take && sel_idx == IW'(i)))
                    overrun_nxt[i] = 1'b1;
                pending_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            overrun   <= '0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_id  <= '0;
            cnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            i2c_start <= 1'b0;
            i2c_addr  <= '0;
            i2c_data  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            i2c_start <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            pending   <= pending_nxt;
            overrun   <= overrun_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    slot_addr[i] <= req_addr[8*i +: 8];
                    slot_data[i] <= req_data[8*i +: 8];
                end
            end

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        i2c_addr  <= slot_addr[sel_idx];
                        i2c_data  <= slot_data[sel_idx];
                        grant_idx <= sel_idx;
                        grant_id  <= 3'(sel_idx);
                        i2c_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i2c_done) begin
                        for (int i = 0; i < NUM_REQ; i++)
                            ack[i] <= (grant_idx == IW'(i));
                        err    <= i2c_nack;
                        rr_ptr <= rr_next;
                        cnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
`ifdef I2C_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        err    <= 1'b1;
                        rr_ptr <= rr_next;
                        cnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                GAP: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter with a short gap and timeout.
module tb_i2c_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  overrun;
    logic        clr_overrun;
    logic        i2c_start;
    logic [7:0]  i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_done;
    logic        i2c_nack;
    logic        err;
    logic [2:0]  grant_id;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    i2c_req_arbiter #(.NUM_REQ(4), .GAP_CYCLES(8), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .overrun(overrun), .clr_overrun(clr_overrun),
        .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .err(err),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req = '0; req_addr = '0; req_data = '0;
        clr_overrun = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic wait_start(output bit ok);
        for (int n = 0; n < 60 && !i2c_start; n++) tick;
        ok = i2c_start;
    endtask

    task automatic send_done(input logic nack);
        i2c_done = 1'b1; i2c_nack = nack;
        tick;
        i2c_done = 1'b0; i2c_nack = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({ack, overrun, i2c_start, i2c_addr, i2c_data, err, grant_id, busy} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {ack, overrun, i2c_start, i2c_addr, i2c_data, err, grant_id, busy});
        end
    endtask

    task automatic test_single;
        bit ok;
        do_reset;
        req = 4'b0010; req_addr[15:8] = 8'h10; req_data[15:8] = 8'h05;
        tick;
        req = '0;
        checks++;
        if (i2c_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b expected 0", i2c_start); end
        tick;
        checks++;
        if ({i2c_start, i2c_addr, i2c_data, grant_id, busy} !== {1'b1, 8'h10, 8'h05, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_start: got start=%b addr=%h data=%h gid=%0d busy=%b expected 1/10/05/1/1",
                     i2c_start, i2c_addr, i2c_data, grant_id, busy);
        end
        tick;
        checks++;
        if (i2c_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", i2c_start); end
        tick; tick; tick;
        send_done(1'b0);
        checks++;
        if ({ack, err} !== {4'b0010, 1'b0}) begin
            errors++; $display("FAIL single_ack: got ack=%b err=%b expected 0010/0", ack, err);
        end
        tick;
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_width: got %b expected 0000", ack); end
        for (int k = 2; k <= 7; k++) tick;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b expected 1", busy); end
        tick;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin;
        bit ok;
        int done_cyc;
        logic [2:0] order [4] = '{3'd0, 3'd1, 3'd3, 3'd0};
        do_reset;
        req_addr = 32'hA3A2A1A0; req_data = 32'hB3B2B1B0;
        req = 4'b1011;
        tick;
        req = '0;
        done_cyc = -1;
        for (int s = 0; s < 4; s++) begin
            wait_start(ok);
            checks++;
            if (!ok || grant_id !== order[s] || i2c_addr !== {5'b10100, order[s]}) begin
                errors++;
                $display("FAIL rr_grant%0d: got ok=%b gid=%0d addr=%h expected gid=%0d", s, ok, grant_id, i2c_addr, order[s]);
            end
            if (done_cyc >= 0) begin
                checks++;
                if (cyc - done_cyc !== 9) begin
                    errors++; $display("FAIL rr_gap%0d: got %0d cycles expected 9", s, cyc - done_cyc);
                end
            end
            tick;
            send_done(1'b0);
            done_cyc = cyc;
            if (s == 2) begin
                req = 4'b1001;
                tick;
                req = '0;
            end
        end
    endtask

    task automatic test_overrun;
        bit ok;
        do_reset;
        req_addr[23:16] = 8'h42; req_data[23:16] = 8'h11; req_addr[7:0] = 8'h40; req_data[7:0] = 8'h00;
        req = 4'b0101;
        tick;
        req = '0;
        wait_start(ok);
        checks++;
        if (!ok || grant_id !== 3'd0) begin errors++; $display("FAIL ovr_first_grant: got ok=%b gid=%0d expected 0", ok, grant_id); end
        tick;
        req_data[23:16] = 8'h22;
        req = 4'b0100;
        tick;
        req = '0;
        checks++;
        if (overrun !== 4'b0100) begin errors++; $display("FAIL ovr_set: got %b expected 0100", overrun); end
        send_done(1'b0);
        wait_start(ok);
        checks++;
        if (!ok || grant_id !== 3'd2 || i2c_data !== 8'h22 || i2c_addr !== 8'h42) begin
            errors++; $display("FAIL ovr_latest: got gid=%0d addr=%h data=%h expected 2/42/22", grant_id, i2c_addr, i2c_data);
        end
        tick;
        send_done(1'b0);
        checks++;
        if (overrun !== 4'b0100) begin errors++; $display("FAIL ovr_sticky: got %b expected 0100", overrun); end
        clr_overrun = 1'b1;
        tick;
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clear: got %b expected 0000", overrun); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        do_reset;
        req_addr[15:8] = 8'h21; req_data[15:8] = 8'h01;
        req = 4'b0010;
        tick;
        req_data[15:8] = 8'h02;
        tick;
        req = '0;
        checks++;
        if (i2c_start !== 1'b1 || i2c_data !== 8'h01 || overrun !== 4'b0000) begin
            errors++; $display("FAIL b2b_first: got start=%b data=%h ovr=%b expected 1/01/0000", i2c_start, i2c_data, overrun);
        end
        tick;
        send_done(1'b0);
        wait_start(ok);
        checks++;
        if (!ok || grant_id !== 3'd1 || i2c_data !== 8'h02) begin
            errors++; $display("FAIL b2b_repend: got ok=%b gid=%0d data=%h expected 1/1/02", ok, grant_id, i2c_data);
        end
    endtask

    task automatic test_nack;
        bit ok;
        do_reset;
        req_addr[31:24] = 8'h33; req_data[31:24] = 8'h44;
        req = 4'b1000;
        tick;
        req = '0;
        wait_start(ok);
        tick;
        send_done(1'b1);
        checks++;
        if ({ack, err} !== {4'b1000, 1'b1}) begin errors++; $display("FAIL nack_pulse: got ack=%b err=%b expected 1000/1", ack, err); end
        req_addr[7:0] = 8'h55; req_data[7:0] = 8'h66;
        req = 4'b0001;
        tick;
        req = '0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL nack_err_width: got %b expected 0", err); end
        wait_start(ok);
        checks++;
        if (!ok || grant_id !== 3'd0 || i2c_addr !== 8'h55) begin
            errors++; $display("FAIL nack_next_grant: got ok=%b gid=%0d addr=%h expected 1/0/55", ok, grant_id, i2c_addr);
        end
        tick;
        send_done(1'b0);
        checks++;
        if ({ack, err} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL nack_next_ack: got ack=%b err=%b expected 0001/0", ack, err); end
    endtask

    task automatic test_timeout;
        bit ok;
        bit ack_seen;
        bit err_seen;
        int s_cyc;
        do_reset;
        req = 4'b0010;
        tick;
        req = '0;
        wait_start(ok);
        s_cyc = cyc;
        ack_seen = 1'b0;
        err_seen = 1'b0;
`ifdef I2C_TIMEOUT_EN
        for (int n = 0; n < 40 && !err; n++) begin
            tick;
            if (ack !== 4'b0000) ack_seen = 1'b1;
        end
        checks++;
        if (err !== 1'b1 || cyc - s_cyc !== 21 || ack_seen) begin
            errors++; $display("FAIL timeout_err: got err=%b at +%0d ack_seen=%b expected 1 at +21 no ack", err, cyc - s_cyc, ack_seen);
        end
        for (int n = 0; n < 8; n++) tick;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b expected 0", busy); end
`else
        for (int n = 0; n < 40; n++) begin
            tick;
            if (ack !== 4'b0000) ack_seen = 1'b1;
            if (err !== 1'b0) err_seen = 1'b1;
        end
        checks++;
        if (busy !== 1'b1 || ack_seen || err_seen) begin
            errors++; $display("FAIL no_timeout_wait: got busy=%b ack_seen=%b err_seen=%b expected 1/0/0", busy, ack_seen, err_seen);
        end
`endif
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit start_seen;
        do_reset;
        req_addr[23:16] = 8'h77; req_data[23:16] = 8'h88;
        req = 4'b0100;
        tick;
        req = '0;
        wait_start(ok);
        req = 4'b0001;
        tick;
        req = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, overrun, i2c_start, i2c_addr, i2c_data, err, grant_id, busy} !== 33'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %0h expected 0",
                     {ack, overrun, i2c_start, i2c_addr, i2c_data, err, grant_id, busy});
        end
        tick;
        rst_n = 1'b1;
        tick;
        send_done(1'b0);
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL mid_reset_no_ack: got %b expected 0000", ack); end
        start_seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick;
            if (i2c_start || busy) start_seen = 1'b1;
        end
        checks++;
        if (start_seen) begin errors++; $display("FAIL mid_reset_pending: got start/busy activity expected none"); end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; req_addr = '0; req_data = '0;
        clr_overrun = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_overrun;
        test_back_to_back;
        test_nack;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
